// File: rtl/tlul_device_adapter.sv
`default_nettype none
// ============================================================================
//  Module      : tlul_device_adapter (plus tlul_pkg)
//  Description : Responder-side TL-UL bridge. Checks A-channel legality,
//                drives a req/gnt/rvalid device port and returns in-order
//                D-channel responses, buffering device data against
//                D-channel backpressure.
//  Revision    : 1.0 - initial release
// ============================================================================

package tlul_pkg;
  localparam logic [2:0] c_op_put_full        = 3'h0;
  localparam logic [2:0] c_op_put_partial     = 3'h1;
  localparam logic [2:0] c_op_get             = 3'h4;
  localparam logic [2:0] c_op_access_ack      = 3'h0;
  localparam logic [2:0] c_op_access_ack_data = 3'h1;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic [15:0] a_user;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic [0:0]  d_sink;
    logic [31:0] d_data;
    logic [15:0] d_user;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;
endpackage

module tlul_device_adapter #(
  parameter int Outstanding = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  tlul_pkg::tl_h2d_t tl_i,
  output tlul_pkg::tl_d2h_t tl_o,
  output logic              req_o,
  input  logic              gnt_i,
  output logic              we_o,
  output logic [31:0]       addr_o,
  output logic [31:0]       wdata_o,
  output logic [3:0]        be_o,
  input  logic              rvalid_i,
  input  logic [31:0]       rdata_i,
  input  logic              err_i
);
  import tlul_pkg::*;

  localparam int unsigned c_pw = (Outstanding > 1) ? $clog2(Outstanding) : 1;
  localparam int unsigned c_cw = $clog2(Outstanding + 1);

  // Pointer advance with wrap at the configured depth (need not be a power of two)
  function automatic logic [c_pw-1:0] f_inc(input logic [c_pw-1:0] p);
    return (p == c_pw'(Outstanding - 1)) ? '0 : p + 1'b1;
  endfunction

  // Request FIFO storage: one entry per accepted beat
  logic            r_rq_get  [Outstanding];
  logic [1:0]      r_rq_size [Outstanding];
  logic [7:0]      r_rq_src  [Outstanding];
  logic            r_rq_lerr [Outstanding];
  logic [c_pw-1:0] r_rq_wp, r_rq_rp;
  logic [c_cw-1:0] r_rq_cnt;

  // Response FIFO storage: one entry per device rvalid beat
  logic [31:0]     r_rs_data [Outstanding];
  logic            r_rs_err  [Outstanding];
  logic [c_pw-1:0] r_rs_wp, r_rs_rp;
  logic [c_cw-1:0] r_rs_cnt;

  logic            r_d_valid;

  logic            w_op_ok, w_size_ok, w_align_ok, w_mask_ok, w_legal;
  logic [3:0]      w_full_mask;
  logic            w_rq_full, w_a_ready, w_push;
  logic            w_head_get, w_head_lerr;
  logic [1:0]      w_head_size;
  logic [7:0]      w_head_src;
  logic            w_d_fire, w_rs_pop;
  logic [c_pw-1:0] w_rq_rp_nxt;
  logic [c_cw-1:0] w_rq_cnt_nxt, w_rs_cnt_nxt;
  logic            w_head_lerr_nxt, w_d_valid_nxt;
  logic            w_unused;

  // Fields the bridge does not interpret
  assign w_unused = ^{tl_i.a_param, tl_i.a_user};

  // Legality of the presented A-channel beat
  always_comb begin
    w_op_ok     = (tl_i.a_opcode == c_op_get) || (tl_i.a_opcode == c_op_put_full) ||
                  (tl_i.a_opcode == c_op_put_partial);
    w_size_ok   = (tl_i.a_size != 2'd3);
    w_align_ok  = 1'b1;
    w_full_mask = 4'hF;
    case (tl_i.a_size)
      2'd0: w_full_mask = 4'b0001 << tl_i.a_address[1:0];
      2'd1: begin
        w_align_ok  = !tl_i.a_address[0];
        w_full_mask = tl_i.a_address[1] ? 4'b1100 : 4'b0011;
      end
      default: w_align_ok = (tl_i.a_address[1:0] == 2'b00);
    endcase
    w_mask_ok = (tl_i.a_opcode != c_op_put_full) || (tl_i.a_mask == w_full_mask);
    w_legal   = w_op_ok && w_size_ok && w_align_ok && w_mask_ok;
  end

  // Acceptance: illegal beats are absorbed locally, legal beats need the grant
  assign w_rq_full = (r_rq_cnt == c_cw'(Outstanding));
  assign w_a_ready = !w_rq_full && (!w_legal || gnt_i);
  assign w_push    = tl_i.a_valid && w_a_ready;

  assign req_o   = tl_i.a_valid && w_legal && !w_rq_full && !rst_i;
  assign we_o    = (tl_i.a_opcode != c_op_get);
  assign addr_o  = {tl_i.a_address[31:2], 2'b00};
  assign wdata_o = tl_i.a_data;
  assign be_o    = (tl_i.a_opcode == c_op_get) ? 4'hF : tl_i.a_mask;

  assign w_head_get  = r_rq_get[r_rq_rp];
  assign w_head_size = r_rq_size[r_rq_rp];
  assign w_head_src  = r_rq_src[r_rq_rp];
  assign w_head_lerr = r_rq_lerr[r_rq_rp];

  assign w_d_fire = r_d_valid && tl_i.d_ready;
  assign w_rs_pop = w_d_fire && !w_head_lerr;

  // Post-edge FIFO state, used to register d_valid for the upcoming head
  always_comb begin
    w_rq_rp_nxt  = w_d_fire ? f_inc(r_rq_rp) : r_rq_rp;
    w_rq_cnt_nxt = r_rq_cnt + c_cw'(w_push) - c_cw'(w_d_fire);
    w_rs_cnt_nxt = r_rs_cnt + c_cw'(rvalid_i) - c_cw'(w_rs_pop);
    // The next head is the beat being pushed right now when the FIFO drains to it
    if (w_push && (w_rq_rp_nxt == r_rq_wp)) begin
      w_head_lerr_nxt = !w_legal;
    end else begin
      w_head_lerr_nxt = r_rq_lerr[w_rq_rp_nxt];
    end
    w_d_valid_nxt = (w_rq_cnt_nxt != '0) && (w_head_lerr_nxt || (w_rs_cnt_nxt != '0));
  end

  // Request FIFO bookkeeping
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rq_wp  <= '0;
      r_rq_rp  <= '0;
      r_rq_cnt <= '0;
      for (int i = 0; i < Outstanding; i++) begin
        r_rq_get[i]  <= 1'b0;
        r_rq_size[i] <= '0;
        r_rq_src[i]  <= '0;
        r_rq_lerr[i] <= 1'b0;
      end
    end else begin
      if (w_push) begin
        r_rq_get[r_rq_wp]  <= (tl_i.a_opcode == c_op_get);
        r_rq_size[r_rq_wp] <= tl_i.a_size;
        r_rq_src[r_rq_wp]  <= tl_i.a_source;
        r_rq_lerr[r_rq_wp] <= !w_legal;
        r_rq_wp            <= f_inc(r_rq_wp);
      end
      r_rq_rp  <= w_rq_rp_nxt;
      r_rq_cnt <= w_rq_cnt_nxt;
    end
  end

  // Response FIFO bookkeeping; every device beat is captured
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rs_wp  <= '0;
      r_rs_rp  <= '0;
      r_rs_cnt <= '0;
      for (int i = 0; i < Outstanding; i++) begin
        r_rs_data[i] <= '0;
        r_rs_err[i]  <= 1'b0;
      end
    end else begin
      if (rvalid_i) begin
        r_rs_data[r_rs_wp] <= rdata_i;
        r_rs_err[r_rs_wp]  <= err_i;
        r_rs_wp            <= f_inc(r_rs_wp);
      end
      if (w_rs_pop) begin
        r_rs_rp <= f_inc(r_rs_rp);
      end
      r_rs_cnt <= w_rs_cnt_nxt;
    end
  end

  // Registered D-channel valid
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_d_valid <= 1'b0;
    end else begin
      r_d_valid <= w_d_valid_nxt;
    end
  end

  // D-channel fields come from the FIFO heads and are zero when idle
  always_comb begin
    tl_o         = '0;
    tl_o.a_ready = w_a_ready;
    if (r_d_valid) begin
      tl_o.d_valid  = 1'b1;
      tl_o.d_opcode = w_head_get ? c_op_access_ack_data : c_op_access_ack;
      tl_o.d_size   = w_head_size;
      tl_o.d_source = w_head_src;
      tl_o.d_error  = w_head_lerr ? 1'b1 : r_rs_err[r_rs_rp];
      tl_o.d_data   = (w_head_get && !w_head_lerr) ? r_rs_data[r_rs_rp] : 32'h0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tlul_device_adapter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tlul_device_adapter
//  Description : Self-checking bench for tlul_device_adapter: vector table
//                of single transactions plus pipelined, stall and reset
//                sequences against a small device model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tlul_device_adapter;
  import tlul_pkg::*;

  logic              clk_i = 1'b0;
  logic              rst_i;
  tl_h2d_t           tl_i;
  tl_d2h_t           tl_o;
  logic              req_o, gnt_i, we_o;
  logic [31:0]       addr_o, wdata_o;
  logic [3:0]        be_o;
  logic              rvalid_i, err_i;
  logic [31:0]       rdata_i;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  tlul_device_adapter #(.Outstanding(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .tl_i(tl_i), .tl_o(tl_o),
    .req_o(req_o), .gnt_i(gnt_i), .we_o(we_o), .addr_o(addr_o),
    .wdata_o(wdata_o), .be_o(be_o), .rvalid_i(rvalid_i),
    .rdata_i(rdata_i), .err_i(err_i)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- device model ----------------
  typedef struct { int due; logic [31:0] data; logic err; } pend_t;
  pend_t       pend_q[$];
  int          dly = 1;
  logic [31:0] dev_rdata = '0;
  logic        dev_err = 1'b0;
  int          gnt_count = 0;
  logic [31:0] g_addr;
  logic [3:0]  g_be;
  logic        g_we;

  initial begin
    rvalid_i = 1'b0; rdata_i = '0; err_i = 1'b0;
    forever begin
      @(posedge clk_i); #1;
      if (rst_i) pend_q.delete();
      rvalid_i = 1'b0; rdata_i = '0; err_i = 1'b0;
      if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
        rvalid_i = 1'b1;
        rdata_i  = pend_q[0].data;
        err_i    = pend_q[0].err;
        void'(pend_q.pop_front());
      end
      @(negedge clk_i);
      if (rst_i) begin
        pend_q.delete();
      end else if (req_o && gnt_i) begin
        pend_t p;
        p.due = cyc + dly; p.data = dev_rdata; p.err = dev_err;
        pend_q.push_back(p);
        gnt_count++;
        g_addr = addr_o; g_be = be_o; g_we = we_o;
      end
    end
  end

  // ---------------- response monitor ----------------
  typedef struct {
    logic [2:0] op; logic [1:0] size; logic [7:0] src;
    logic [31:0] data; logic err; logic zero; int cyc;
  } rsp_t;
  rsp_t rsp_q[$];

  initial forever begin
    @(negedge clk_i);
    if (!rst_i && tl_o.d_valid && tl_i.d_ready) begin
      rsp_t r;
      r.op = tl_o.d_opcode; r.size = tl_o.d_size; r.src = tl_o.d_source;
      r.data = tl_o.d_data; r.err = tl_o.d_error; r.cyc = cyc;
      r.zero = (tl_o.d_param == 3'h0) && (tl_o.d_sink == 1'b0) && (tl_o.d_user == 16'h0);
      rsp_q.push_back(r);
    end
  end

  // ---------------- helpers ----------------
  task automatic drive_a(input logic [2:0] op, input logic [1:0] sz, input logic [31:0] ad,
                         input logic [3:0] mk, input logic [31:0] dt, input logic [7:0] src);
    tl_i.a_valid = 1'b1; tl_i.a_opcode = op; tl_i.a_size = sz; tl_i.a_address = ad;
    tl_i.a_mask = mk; tl_i.a_data = dt; tl_i.a_source = src;
  endtask

  // Present one beat (starting at posedge+1) until accepted, then drop a_valid
  task automatic send(input logic [2:0] op, input logic [1:0] sz, input logic [31:0] ad,
                      input logic [3:0] mk, input logic [31:0] dt, input logic [7:0] src,
                      output int acc, output bit ok);
    drive_a(op, sz, ad, mk, dt, src);
    ok = 1'b0; acc = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_i);
      if (tl_o.a_ready) begin ok = 1'b1; acc = cyc; break; end
    end
    @(posedge clk_i); #1;
    tl_i.a_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (rsp_q.size() >= n) begin ok = 1'b1; break; end
      @(posedge clk_i); #1;
    end
  endtask

  function automatic logic [48:0] dsnap();
    return {tl_o.d_valid, tl_o.d_opcode, tl_o.d_size, tl_o.d_source, tl_o.d_data, tl_o.d_error};
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic [2:0] op; logic [1:0] sz; logic [31:0] addr; logic [3:0] mask;
    logic [31:0] data; logic [7:0] src; logic [31:0] rdata; logic derr;
    logic exp_req; logic [31:0] exp_addr; logic [3:0] exp_be; logic exp_we;
    logic [2:0] exp_op; logic exp_err; logic [31:0] exp_data; int exp_lat;
  } vec_t;

  function automatic vec_t mk(input logic [2:0] op, input logic [1:0] sz, input logic [31:0] addr,
      input logic [3:0] mask, input logic [31:0] data, input logic [7:0] src,
      input logic [31:0] rdata, input logic derr, input logic exp_req, input logic [31:0] exp_addr,
      input logic [3:0] exp_be, input logic exp_we, input logic [2:0] exp_op, input logic exp_err,
      input logic [31:0] exp_data, input int exp_lat);
    vec_t v;
    v.op = op; v.sz = sz; v.addr = addr; v.mask = mask; v.data = data; v.src = src;
    v.rdata = rdata; v.derr = derr; v.exp_req = exp_req; v.exp_addr = exp_addr;
    v.exp_be = exp_be; v.exp_we = exp_we; v.exp_op = exp_op; v.exp_err = exp_err;
    v.exp_data = exp_data; v.exp_lat = exp_lat;
    return v;
  endfunction

  localparam int NV = 13;
  vec_t vecs[NV];

  initial begin
    bit ok, ok2;
    int acc, acc1, g0, first_rdy, leak, unstable;
    logic [48:0] snap;

    vecs[0]  = mk(3'h4, 2'd2, 32'h100, 4'hF, 32'h0,        8'h15, 32'hDEADBEEF, 1'b0, 1, 32'h100, 4'hF, 0, 3'h1, 0, 32'hDEADBEEF, 2);
    vecs[1]  = mk(3'h1, 2'd0, 32'h203, 4'h8, 32'h11223344, 8'h03, 32'h12345678, 1'b0, 1, 32'h200, 4'h8, 1, 3'h0, 0, 32'h0, 2);
    vecs[2]  = mk(3'h0, 2'd2, 32'h010, 4'hF, 32'hCAFEF00D, 8'h04, 32'h0,        1'b0, 1, 32'h010, 4'hF, 1, 3'h0, 0, 32'h0, 2);
    vecs[3]  = mk(3'h4, 2'd1, 32'h042, 4'hC, 32'h0,        8'h05, 32'h0BAD0BAD, 1'b1, 1, 32'h040, 4'hF, 0, 3'h1, 1, 32'h0BAD0BAD, 2);
    vecs[4]  = mk(3'h3, 2'd2, 32'h000, 4'hF, 32'h0,        8'h06, 32'h0,        1'b0, 0, 32'h0,   4'h0, 0, 3'h0, 1, 32'h0, 1);
    vecs[5]  = mk(3'h4, 2'd2, 32'h102, 4'hF, 32'h0,        8'h07, 32'h0,        1'b0, 0, 32'h0,   4'h0, 0, 3'h1, 1, 32'h0, 1);
    vecs[6]  = mk(3'h0, 2'd2, 32'h000, 4'h7, 32'h0,        8'h08, 32'h0,        1'b0, 0, 32'h0,   4'h0, 0, 3'h0, 1, 32'h0, 1);
    vecs[7]  = mk(3'h4, 2'd3, 32'h000, 4'hF, 32'h0,        8'h09, 32'h0,        1'b0, 0, 32'h0,   4'h0, 0, 3'h1, 1, 32'h0, 1);
    vecs[8]  = mk(3'h0, 2'd1, 32'h002, 4'hC, 32'h5555AAAA, 8'h0A, 32'h0,        1'b0, 1, 32'h000, 4'hC, 1, 3'h0, 0, 32'h0, 2);
    vecs[9]  = mk(3'h0, 2'd0, 32'h001, 4'h2, 32'h0000BB00, 8'h0B, 32'h0,        1'b0, 1, 32'h000, 4'h2, 1, 3'h0, 0, 32'h0, 2);
    vecs[10] = mk(3'h0, 2'd1, 32'h002, 4'h3, 32'h0,        8'h0C, 32'h0,        1'b0, 0, 32'h0,   4'h0, 0, 3'h0, 1, 32'h0, 1);
    vecs[11] = mk(3'h4, 2'd1, 32'h001, 4'hF, 32'h0,        8'h0D, 32'h0,        1'b0, 0, 32'h0,   4'h0, 0, 3'h1, 1, 32'h0, 1);
    vecs[12] = mk(3'h1, 2'd2, 32'h001, 4'hF, 32'h0,        8'h0E, 32'h0,        1'b0, 0, 32'h0,   4'h0, 0, 3'h0, 1, 32'h0, 1);

    // Reset state, with a legal request pending to show req_o stays low
    rst_i = 1'b1; gnt_i = 1'b1; tl_i = '0; tl_i.d_ready = 1'b1;
    drive_a(3'h4, 2'd2, 32'h0, 4'hF, 32'h0, 8'h0);
    repeat (3) @(negedge clk_i);
    chk("reset req_o", req_o, 1'b0);
    chk("reset d fields", dsnap(), '0);
    rst_i = 1'b0; tl_i.a_valid = 1'b0;
    @(posedge clk_i); #1;
    chk("post-reset a_ready/d_valid", {tl_o.a_ready, tl_o.d_valid}, 2'b10);

    // Table of single transactions
    for (int i = 0; i < NV; i++) begin
      vec_t v;
      rsp_t r;
      v = vecs[i];
      rsp_q.delete();
      g0 = gnt_count; dev_rdata = v.rdata; dev_err = v.derr;
      send(v.op, v.sz, v.addr, v.mask, v.data, v.src, acc, ok);
      chk($sformatf("v%0d accept", i), ok, 1'b1);
      wait_rsp(1, ok2);
      chk($sformatf("v%0d rsp seen", i), ok2, 1'b1);
      chk($sformatf("v%0d grants", i), gnt_count - g0, v.exp_req ? 1 : 0);
      if (v.exp_req)
        chk($sformatf("v%0d device", i), {g_addr, g_be, g_we}, {v.exp_addr, v.exp_be, v.exp_we});
      if (ok2) begin
        r = rsp_q[0];
        chk($sformatf("v%0d rsp", i), {r.op, r.size, r.src, r.err, r.zero, r.data},
            {v.exp_op, v.sz, v.src, v.exp_err, 1'b1, v.exp_data});
        chk($sformatf("v%0d latency", i), r.cyc - acc, v.exp_lat);
      end
    end

    // Pipelined: two in flight, third waits for the first pop
    dly = 5; rsp_q.delete();
    drive_a(3'h4, 2'd2, 32'h300, 4'hF, 32'h0, 8'h21); dev_rdata = 32'h11110001;
    @(negedge clk_i); acc1 = cyc;
    chk("pipe a_ready 1", tl_o.a_ready, 1'b1);
    @(posedge clk_i); #1;
    drive_a(3'h4, 2'd2, 32'h304, 4'hF, 32'h0, 8'h22); dev_rdata = 32'h22220002;
    @(negedge clk_i);
    chk("pipe a_ready 2", tl_o.a_ready, 1'b1);
    @(posedge clk_i); #1;
    drive_a(3'h4, 2'd2, 32'h308, 4'hF, 32'h0, 8'h23); dev_rdata = 32'h33330003;
    first_rdy = -1; leak = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_i);
      if (tl_o.a_ready) begin first_rdy = cyc; break; end
      if (req_o) leak++;
    end
    @(posedge clk_i); #1; tl_i.a_valid = 1'b0;
    chk("pipe full stall cycles", first_rdy - acc1, 7);
    chk("pipe req_o while full", leak, 0);
    wait_rsp(3, ok);
    chk("pipe 3 rsps", ok, 1'b1);
    if (ok) begin
      chk("pipe order src", {rsp_q[0].src, rsp_q[1].src, rsp_q[2].src}, 24'h212223);
      chk("pipe data 0", rsp_q[0].data, 32'h11110001);
      chk("pipe data 2", rsp_q[2].data, 32'h33330003);
    end

    // Stall: legal slow Get then illegal Get, d_ready low for 10 cycles
    dly = 3; rsp_q.delete(); tl_i.d_ready = 1'b0; dev_rdata = 32'hA1A1A1A1; dev_err = 1'b0;
    send(3'h4, 2'd2, 32'h400, 4'hF, 32'h0, 8'h01, acc, ok);
    send(3'h4, 2'd2, 32'h401, 4'hF, 32'h0, 8'h02, acc, ok2);
    chk("stall accepts", {ok, ok2}, 2'b11);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_i);
      if (tl_o.d_valid) begin ok = 1'b1; break; end
    end
    chk("stall d_valid", ok, 1'b1);
    snap = dsnap(); unstable = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      if (dsnap() !== snap) unstable++;
    end
    chk("stall stable", unstable, 0);
    chk("stall head src", snap[40:33], 8'h01);
    @(posedge clk_i); #1; tl_i.d_ready = 1'b1;
    wait_rsp(2, ok);
    chk("stall 2 rsps", ok, 1'b1);
    if (ok) begin
      chk("stall rsp0", {rsp_q[0].src, rsp_q[0].op, rsp_q[0].err, rsp_q[0].data}, {8'h01, 3'h1, 1'b0, 32'hA1A1A1A1});
      chk("stall rsp1", {rsp_q[1].src, rsp_q[1].op, rsp_q[1].err, rsp_q[1].data}, {8'h02, 3'h1, 1'b1, 32'h0});
    end

    // Reset with two outstanding and d_valid high
    dly = 5; rsp_q.delete(); tl_i.d_ready = 1'b0;
    send(3'h4, 2'd2, 32'h600, 4'hF, 32'h0, 8'h31, acc, ok);
    send(3'h4, 2'd2, 32'h604, 4'hF, 32'h0, 8'h32, acc, ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_i);
      if (tl_o.d_valid) begin ok = 1'b1; break; end
    end
    chk("rst pre d_valid", ok, 1'b1);
    @(posedge clk_i); #1; rst_i = 1'b1; #1;
    chk("rst drops d_valid", tl_o.d_valid, 1'b0);
    @(negedge clk_i); @(negedge clk_i); rst_i = 1'b0;
    @(posedge clk_i); #1;
    chk("rst release a_ready/d_valid", {tl_o.a_ready, tl_o.d_valid}, 2'b10);
    dly = 1; tl_i.d_ready = 1'b1; rsp_q.delete(); dev_rdata = 32'h55AA55AA;
    send(3'h4, 2'd2, 32'h500, 4'hF, 32'h0, 8'h33, acc, ok);
    wait_rsp(1, ok2);
    chk("rst next get", ok2, 1'b1);
    if (ok2)
      chk("rst next rsp", {rsp_q[0].src, rsp_q[0].err, rsp_q[0].data}, {8'h33, 1'b0, 32'h55AA55AA});
    repeat (10) @(posedge clk_i);
    #1;
    chk("rst no stale rsps", rsp_q.size(), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
